bram_sdp_be: RTL and testbench
==============================

BRAM_SDP_BE -- requirements
Module: bram_sdp_be

Interface
REQ-001 SHALL have parameter DW, default 128: data width in bits; multiple of 8.
REQ-002 SHALL have parameter WL, default 16: depth in words.
REQ-003 SHALL have parameter AW, default 13: byte-address width.
REQ-004 SHALL have parameter ASH, default 2: byte-to-word shift; word index = address >> ASH.
REQ-005 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values are 1 and 2.
REQ-006 SHALL have parameter WR_MODE, default 0: same-word collision policy; 0 = read-first, 1 = write-first.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port WEN, input, 1 bit: write request.
REQ-010 SHALL have port WA, input, AW bits: write byte address.
REQ-011 SHALL have port WE, input, DW/8 bits: byte write enables; bit i covers Di[8i+7:8i].
REQ-012 SHALL have port Di, input, DW bits: write data.
REQ-013 SHALL have port REN, input, 1 bit: read request.
REQ-014 SHALL have port RA, input, AW bits: read byte address.
REQ-015 SHALL have port Do, output, DW bits: read data.
REQ-016 SHALL have port DoV, output, 1 bit: Do valid, a one-cycle pulse per accepted read.
REQ-017 SHALL have port BUSY, output, 1 bit: high while the memory clear is in progress.

Function
REQ-018 SHALL use a two-state FSM, CLEAR and READY; RSTN low forces CLEAR.
REQ-019 In CLEAR, SHALL write zero to word index cnt each cycle, cnt running 0..WL-1; SHALL go to READY after writing word WL-1; BUSY=1 throughout CLEAR (WL cycles).
REQ-020 While BUSY=1, SHALL ignore WEN and REN: no array write, no DoV.
REQ-021 In READY, WEN=1 SHALL update only the bytes whose WE bit is 1; WE=0 SHALL change nothing.
REQ-022 In READY, REN=1 SHALL produce Do and DoV=1 exactly RD_LAT cycles after the sampling edge; back-to-back reads SHALL be accepted every cycle.
REQ-023 RD_LAT=2 SHALL add one output register stage after the array read.
REQ-024 Do SHALL hold its last value when DoV=0; it is not masked.
REQ-025 Word index >= WL on a write SHALL be ignored.
REQ-026 Word index >= WL on a read SHALL return Do=0 with DoV=1 at normal latency.
REQ-027 Same-cycle read and write to the same word: WR_MODE=0 SHALL return the old word; WR_MODE=1 SHALL return the merged new word (enabled bytes new, other bytes old).
REQ-028 Address bits below ASH SHALL be ignored.

Reset
REQ-029 On RSTN low, SHALL asynchronously set Do=0, DoV=0, BUSY=1, cnt=0, and flush all read-pipeline valids.
REQ-030 Reset asserted mid-CLEAR or mid-read SHALL restart CLEAR from word 0 on release; in-flight reads SHALL be dropped with no DoV.
REQ-031 The array itself SHALL NOT be reset asynchronously; its contents SHALL be defined only by the CLEAR sequence.

Structure
REQ-032 A shared package bram_pkg SHALL hold the FSM state encoding (CLEAR, READY) and the WR_MODE constants (WR_READ_FIRST=0, WR_WRITE_FIRST=1).
REQ-033 One sub-module, bram_rd_pipe, SHALL implement the RD_LAT-deep valid/data pipeline, including reset flush.
REQ-034 Parameter legality (DW%8==0; RD_LAT in {1,2}; WR_MODE in {0,1}) SHALL be checked at elaboration.

Verification
REQ-035 Release RSTN -> BUSY=1 for exactly 16 cycles; a REN to word 5 issued during BUSY gives no DoV; after BUSY=0, reads of all words return 0.
REQ-036 Write Di=all 0xAA with WE=0xFFFF to WA=0x10, then Di=all 0x55 with WE=0x0001 to WA=0x10; read RA=0x10 -> Do=0xAA..AA55; DoV arrives 1 cycle later with RD_LAT=1, 2 cycles later with RD_LAT=2.
REQ-037 Word 3 holds 0x1 and is written with 0x2 while read in the same cycle -> Do=0x1 with WR_MODE=0, Do=0x2 with WR_MODE=1.
REQ-038 Read RA=0x40 (word 16, WL=16) -> Do=0 with DoV=1; write WA=0x40 -> no word of the array changes.
REQ-039 Pulse RSTN low at clear count 7, then issue REN in the same cycle as a reset during READY -> DoV stays 0, CLEAR restarts at word 0, BUSY=1 for 16 cycles.
REQ-040 Issue REN on 8 consecutive cycles to words 0..7 holding values 0..7 -> 8 consecutive DoV pulses with Do=0..7 in order.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the byte-enabled simple dual-port block RAM:
// controller state encoding and collision-policy constants.
package bram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } bram_state_t;

   localparam int WR_READ_FIRST  = 0;
   localparam int WR_WRITE_FIRST = 1;

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-side valid/data pipeline of depth RD_LAT. Data registers load only
// with their valid, so the output holds its last value between reads.
module bram_rd_pipe #(
   parameter int DW     = 128,
   parameter int RD_LAT = 1
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          in_v,
   input  logic [DW-1:0] in_d,
   output logic          out_v,
   output logic [DW-1:0] out_d
);

   localparam int unsigned LAT = RD_LAT;

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("bram_rd_pipe: RD_LAT must be 1 or 2");
   end

   logic [LAT-1:0] v_q;
   logic [DW-1:0]  d_q [LAT];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         v_q <= '0;
         for (int unsigned i = 0; i < LAT; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q[0] <= in_v;
         if (in_v) begin
            d_q[0] <= in_d;
         end
         for (int unsigned i = 1; i < LAT; i++) begin
            v_q[i] <= v_q[i-1];
            if (v_q[i-1]) begin
               d_q[i] <= d_q[i-1];
            end
         end
      end
   end

   assign out_v = v_q[LAT-1];
   assign out_d = d_q[LAT-1];

endmodule

// File: rtl/bram_sdp_be.sv
// Simple dual-port RAM with byte write enables, self-clearing after reset,
// configurable read latency and same-word collision policy.
module bram_sdp_be
   import bram_pkg::*;
#(
   parameter int DW      = 128,
   parameter int WL      = 16,
   parameter int AW      = 13,
   parameter int ASH     = 2,
   parameter int RD_LAT  = 1,
   parameter int WR_MODE = 0
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            WEN,
   input  logic [AW-1:0]   WA,
   input  logic [DW/8-1:0] WE,
   input  logic [DW-1:0]   Di,
   input  logic            REN,
   input  logic [AW-1:0]   RA,
   output logic [DW-1:0]   Do,
   output logic            DoV,
   output logic            BUSY
);

   localparam int unsigned BW   = DW / 8;
   localparam int          CW   = (WL > 1) ? $clog2(WL) : 1;
   localparam logic [31:0] WL_U = 32'(WL);

   if (DW % 8 != 0) begin : g_bad_dw
      $error("bram_sdp_be: DW must be a multiple of 8");
   end
   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("bram_sdp_be: RD_LAT must be 1 or 2");
   end
   if (WR_MODE != WR_READ_FIRST && WR_MODE != WR_WRITE_FIRST) begin : g_bad_mode
      $error("bram_sdp_be: WR_MODE must be 0 or 1");
   end

   logic [DW-1:0] mem [WL];

   bram_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clr_we;

   logic [AW-1:0] widx, ridx;
   logic          w_ok, r_ok, wr_act, rd_act;
   logic [DW-1:0] old_word, rd_word;

   assign widx   = WA >> ASH;
   assign ridx   = RA >> ASH;
   assign w_ok   = 32'(widx) < WL_U;
   assign r_ok   = 32'(ridx) < WL_U;
   assign wr_act = (state_q == READY) && WEN && w_ok;
   assign rd_act = (state_q == READY) && REN;
   assign BUSY   = (state_q == CLEAR);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_we = 1'b1;
            if (cnt_q == CW'(WL - 1)) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   // Array has no reset; its contents come only from the clear sweep.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem[cnt_q] <= '0;
      end else if (wr_act) begin
         for (int unsigned i = 0; i < BW; i++) begin
            if (WE[i]) begin
               mem[widx[CW-1:0]][8*i +: 8] <= Di[8*i +: 8];
            end
         end
      end
   end

   assign old_word = mem[ridx[CW-1:0]];

   always_comb begin
      rd_word = '0;
      if (r_ok) begin
         rd_word = old_word;
         if (WR_MODE == WR_WRITE_FIRST && wr_act && widx == ridx) begin
            for (int unsigned i = 0; i < BW; i++) begin
               if (WE[i]) begin
                  rd_word[8*i +: 8] = Di[8*i +: 8];
               end
            end
         end
      end
   end

   bram_rd_pipe #(
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .in_v  (rd_act),
      .in_d  (rd_word),
      .out_v (DoV),
      .out_d (Do)
   );

endmodule

// File: tb/tb_bram_sdp_be.sv
// Directed bench: one read-first/RD_LAT=1 instance and one write-first/RD_LAT=2
// instance share the same stimulus.
module tb_bram_sdp_be;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          WEN;
   logic [12:0]   WA;
   logic [15:0]   WE;
   logic [127:0]  Di;
   logic          REN;
   logic [12:0]   RA;
   logic [127:0]  do1, do2;
   logic          dov1, dov2, busy1, busy2;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   bram_sdp_be #(.DW(128), .WL(16), .AW(13), .ASH(2), .RD_LAT(1), .WR_MODE(0)) u_rf (
      .CLK(CLK), .RSTN(RSTN), .WEN(WEN), .WA(WA), .WE(WE), .Di(Di),
      .REN(REN), .RA(RA), .Do(do1), .DoV(dov1), .BUSY(busy1)
   );

   bram_sdp_be #(.DW(128), .WL(16), .AW(13), .ASH(2), .RD_LAT(2), .WR_MODE(1)) u_wf (
      .CLK(CLK), .RSTN(RSTN), .WEN(WEN), .WA(WA), .WE(WE), .Di(Di),
      .REN(REN), .RA(RA), .Do(do2), .DoV(dov2), .BUSY(busy2)
   );

   typedef struct {
      logic         wen;
      logic [12:0]  wa;
      logic [15:0]  we;
      logic [127:0] di;
      logic         ren;
      logic [12:0]  ra;
      logic [127:0] e1;
      logic [127:0] e2;
   } vec_t;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      WEN = 1'b0; WE = '0; REN = 1'b0;
   endtask

   // Single operation, then check RD_LAT=1 at +1 and RD_LAT=2 at +2.
   task automatic apply(input vec_t v, input string nm);
      WEN = v.wen; WA = v.wa; WE = v.we; Di = v.di; REN = v.ren; RA = v.ra;
      tick();
      idle();
      chk({nm, " dov1@1"}, 128'(dov1), 128'(v.ren));
      if (v.ren) chk({nm, " do1"}, do1, v.e1);
      chk({nm, " dov2@1"}, 128'(dov2), 128'd0);
      tick();
      chk({nm, " dov1@2"}, 128'(dov1), 128'd0);
      chk({nm, " dov2@2"}, 128'(dov2), 128'(v.ren));
      if (v.ren) begin
         chk({nm, " do2"}, do2, v.e2);
         chk({nm, " do1 hold"}, do1, v.e1);
      end
   endtask

   // Called at the sample point right after RSTN is released.
   task automatic clear_run(input string nm);
      int  b1 = 0;
      int  b2 = 0;
      bit  seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy1) b1++;
         if (busy2) b2++;
         if (dov1 || dov2) seen = 1'b1;
         if (!busy1 && !busy2) break;
         REN = (i < 4);
         RA  = 13'h14;
         tick();
      end
      REN = 1'b0;
      chk({nm, " busy1 cycles"}, 128'(b1), 128'd16);
      chk({nm, " busy2 cycles"}, 128'(b2), 128'd16);
      chk({nm, " no dov while busy"}, 128'(seen), 128'd0);
   endtask

   task automatic read_all_zero(input string nm);
      vec_t v;
      for (int w = 0; w < 16; w++) begin
         v = '{wen: 1'b0, wa: '0, we: '0, di: '0, ren: 1'b1, ra: 13'(w * 4), e1: '0, e2: '0};
         apply(v, $sformatf("%s w%0d", nm, w));
      end
   endtask

   localparam logic [127:0] AA = {16{8'hAA}};
   localparam logic [127:0] AA55 = {{15{8'hAA}}, 8'h55};

   vec_t tbl [16];

   initial begin
      tbl[0]  = '{1'b1, 13'h010, 16'hFFFF, AA,              1'b0, 13'h000, '0,   '0};
      tbl[1]  = '{1'b1, 13'h010, 16'h0001, {16{8'h55}},     1'b0, 13'h000, '0,   '0};
      tbl[2]  = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h010, AA55, AA55};
      tbl[3]  = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h013, AA55, AA55};
      tbl[4]  = '{1'b1, 13'h00C, 16'hFFFF, 128'h1,          1'b0, 13'h000, '0,   '0};
      tbl[5]  = '{1'b1, 13'h00C, 16'hFFFF, 128'h2,          1'b1, 13'h00C, 128'h1, 128'h2};
      tbl[6]  = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h00C, 128'h2, 128'h2};
      tbl[7]  = '{1'b1, 13'h00E, 16'h0002, {16{8'h77}},     1'b1, 13'h00C, 128'h2, 128'h7702};
      tbl[8]  = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h00C, 128'h7702, 128'h7702};
      tbl[9]  = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h040, '0,   '0};
      tbl[10] = '{1'b1, 13'h040, 16'hFFFF, {16{8'hFF}},     1'b0, 13'h000, '0,   '0};
      tbl[11] = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h000, '0,   '0};
      tbl[12] = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h010, AA55, AA55};
      tbl[13] = '{1'b1, 13'h010, 16'h0000, '0,              1'b0, 13'h000, '0,   '0};
      tbl[14] = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h010, AA55, AA55};
      tbl[15] = '{1'b0, 13'h000, 16'h0000, '0,              1'b1, 13'h1FFC, '0,  '0};

      RSTN = 1'b0; WA = '0; RA = '0; Di = '0;
      idle();
      repeat (3) tick();
      chk("reset do1", do1, '0);
      chk("reset do2", do2, '0);
      chk("reset dov", 128'({dov1, dov2}), 128'd0);
      chk("reset busy", 128'({busy1, busy2}), 128'd3);

      RSTN = 1'b1;
      clear_run("clear0");
      read_all_zero("zero0");

      for (int i = 0; i < 16; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Words 0..7 loaded with 0..7, then eight back-to-back reads.
      for (int w = 0; w < 8; w++) begin
         WEN = 1'b1; WA = 13'(w * 4); WE = 16'hFFFF; Di = 128'(w);
         tick();
      end
      idle();
      tick();
      for (int c = 0; c < 10; c++) begin
         REN = (c < 8);
         RA  = 13'(c * 4);
         tick();
         chk($sformatf("burst dov1 c%0d", c), 128'(dov1), 128'(c < 8));
         if (c < 8) chk($sformatf("burst do1 c%0d", c), do1, 128'(c));
         chk($sformatf("burst dov2 c%0d", c), 128'(dov2), 128'(c >= 1 && c < 9));
         if (c >= 1 && c < 9) chk($sformatf("burst do2 c%0d", c), do2, 128'(c - 1));
      end
      idle();

      // Reset pulse with the clear sweep part-way through (count 7).
      RSTN = 1'b0;
      tick();
      RSTN = 1'b1;
      repeat (7) tick();
      chk("mid-clear busy", 128'({busy1, busy2}), 128'd3);
      RSTN = 1'b0;
      #1;
      chk("mid-clear rst busy", 128'({busy1, busy2}), 128'd3);
      tick();
      RSTN = 1'b1;
      clear_run("clear1");
      read_all_zero("zero1");

      // Reset while a read is in flight and REN is still asserted.
      WEN = 1'b1; WA = 13'h004; WE = 16'hFFFF; Di = 128'h1234;
      tick();
      idle();
      REN = 1'b1; RA = 13'h004;
      tick();
      chk("pre-rst dov1", 128'(dov1), 128'd1);
      chk("pre-rst do1", do1, 128'h1234);
      RSTN = 1'b0;
      #1;
      chk("async rst dov", 128'({dov1, dov2}), 128'd0);
      chk("async rst do1", do1, '0);
      chk("async rst do2", do2, '0);
      tick();
      tick();
      chk("in-flight dropped", 128'({dov1, dov2}), 128'd0);
      REN = 1'b0;
      RSTN = 1'b1;
      clear_run("clear2");
      read_all_zero("zero2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
